// File: rtl/hpdcache_prio_rr_arbiter.sv
// Round-robin or fixed-priority arbiter whose grant is held until the downstream accepts it.
// The grant is dropped early if the granted requester withdraws.
module hpdcache_prio_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter bit          RR = 1'b1,
  localparam int unsigned W = (N == 1) ? 1 : $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         valid_o,
  input  logic         ready_i
);

  typedef enum logic {StIdle, StLocked} state_e;

  localparam logic [W-1:0] LastIdx = W'(N - 1);

  state_e       r_state;
  logic [W-1:0] r_ptr;
  logic [N-1:0] r_lock;

  logic [N-1:0] w_arb_gnt;
  logic [W-1:0] w_arb_idx;
  logic         w_arb_found;
  int unsigned  w_sum;
  logic [W-1:0] w_cand;
  logic [W-1:0] w_lock_idx;
  logic [W-1:0] w_ptr_nxt;

  // Scan upward from the pointer with wrap; ptr + i < 2N, so one subtraction is a full modulo.
  always_comb begin
    w_arb_gnt   = '0;
    w_arb_idx   = '0;
    w_arb_found = 1'b0;
    w_sum       = 0;
    w_cand      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_sum  = RR ? (32'(r_ptr) + i) : i;
      w_cand = W'((w_sum >= N) ? (w_sum - N) : w_sum);
      if (!w_arb_found && req_i[w_cand]) begin
        w_arb_found       = 1'b1;
        w_arb_gnt[w_cand] = 1'b1;
        w_arb_idx         = w_cand;
      end
    end
  end

  always_comb begin
    w_lock_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_lock[i]) begin
        w_lock_idx = W'(i);
      end
    end
  end

  // Outputs are gated by reset so an asynchronous reset drops the grant without a clock edge.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    if (!rst_i) begin
      if (r_state == StIdle) begin
        gnt_o     = w_arb_gnt;
        valid_o   = |req_i;
        gnt_idx_o = w_arb_idx;
      end else begin
        gnt_o     = r_lock & req_i;
        valid_o   = |(r_lock & req_i);
        gnt_idx_o = valid_o ? w_lock_idx : '0;
      end
    end
  end

  always_comb begin
    w_ptr_nxt = (gnt_idx_o == LastIdx) ? '0 : (gnt_idx_o + W'(1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_lock  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (valid_o && ready_i) begin
            if (RR) begin
              r_ptr <= w_ptr_nxt;
            end
          end else if (valid_o) begin
            r_state <= StLocked;
            r_lock  <= gnt_o;
          end
        end
        StLocked: begin
          if (!valid_o) begin
            r_state <= StIdle;
            r_lock  <= '0;
          end else if (ready_i) begin
            r_state <= StIdle;
            r_lock  <= '0;
            if (RR) begin
              r_ptr <= w_ptr_nxt;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_lock  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpdcache_prio_rr_arbiter.sv
// Directed bench for hpdcache_prio_rr_arbiter: round-robin, fixed-priority, N=3 wrap and N=1
// instances share one clock and reset.
module tb_hpdcache_prio_rr_arbiter;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [3:0] req4 = '0, gnt4;
  logic [1:0] idx4;
  logic       valid4, ready4 = 1'b0;

  logic [2:0] req3 = '0, gnt3;
  logic [1:0] idx3;
  logic       valid3, ready3 = 1'b0;

  logic [3:0] reqf = '0, gntf;
  logic [1:0] idxf;
  logic       validf, readyf = 1'b0;

  logic [0:0] req1 = '0, gnt1, idx1;
  logic       valid1, ready1 = 1'b0;

  int total = 0;
  int bad   = 0;

  hpdcache_prio_rr_arbiter #(.N(4), .RR(1'b1)) u_rr4 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req4), .gnt_o(gnt4), .gnt_idx_o(idx4),
    .valid_o(valid4), .ready_i(ready4)
  );
  hpdcache_prio_rr_arbiter #(.N(3), .RR(1'b1)) u_rr3 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req3), .gnt_o(gnt3), .gnt_idx_o(idx3),
    .valid_o(valid3), .ready_i(ready3)
  );
  hpdcache_prio_rr_arbiter #(.N(4), .RR(1'b0)) u_fix4 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(reqf), .gnt_o(gntf), .gnt_idx_o(idxf),
    .valid_o(validf), .ready_i(readyf)
  );
  hpdcache_prio_rr_arbiter #(.N(1), .RR(1'b1)) u_one (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req1), .gnt_o(gnt1), .gnt_idx_o(idx1),
    .valid_o(valid1), .ready_i(ready1)
  );

  // Grant invariants, checked every cycle on the round-robin and fixed-priority instances.
  logic       h4 = 1'b0, hf = 1'b0;
  logic [3:0] pg4 = '0, pgf = '0;
  always @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h4 <= 1'b0;
      hf <= 1'b0;
    end else begin
      assert ($onehot0(gnt4)) else $error("FAIL onehot rr4 gnt=%b", gnt4);
      assert ((gnt4 & ~req4) == 4'b0) else $error("FAIL subset rr4 gnt=%b req=%b", gnt4, req4);
      assert ($onehot0(gntf)) else $error("FAIL onehot fix4 gnt=%b", gntf);
      assert ((gntf & ~reqf) == 4'b0) else $error("FAIL subset fix4 gnt=%b req=%b", gntf, reqf);
      assert ($onehot0(gnt3)) else $error("FAIL onehot rr3 gnt=%b", gnt3);
      if (h4 && ((req4 & pg4) != 4'b0))
        assert (gnt4 == pg4) else $error("FAIL stable rr4 gnt=%b want=%b", gnt4, pg4);
      if (hf && ((reqf & pgf) != 4'b0))
        assert (gntf == pgf) else $error("FAIL stable fix4 gnt=%b want=%b", gntf, pgf);
      h4  <= valid4 && !ready4;
      pg4 <= gnt4;
      hf  <= validf && !readyf;
      pgf <= gntf;
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_i  = 1'b1;
    req4   = '0; ready4 = 1'b0;
    req3   = '0; ready3 = 1'b0;
    reqf   = '0; readyf = 1'b0;
    req1   = '0; ready1 = 1'b0;
    #2;
    rst_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req4  = 4'b1111;
    reqf  = 4'b1111;
    #1;
    total++;
    if ({valid4, gnt4, idx4} !== 7'b0) begin
      bad++;
      $display("FAIL reset_rr4 got=%b want=%b", {valid4, gnt4, idx4}, 7'b0);
    end
    total++;
    if ({validf, gntf, idxf} !== 7'b0) begin
      bad++;
      $display("FAIL reset_fix4 got=%b want=%b", {validf, gntf, idxf}, 7'b0);
    end
    cyc();
    cyc();
    do_reset();
  endtask

  task automatic test_rr_cycle();
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    logic [3:0] eg;
    do_reset();
    req4   = 4'b1111;
    ready4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      eg = 4'(1 << exp_idx[k]);
      total++;
      if ({valid4, gnt4, idx4} !== {1'b1, eg, 2'(exp_idx[k])}) begin
        bad++;
        $display("FAIL rr_cycle[%0d] got=%b want=%b", k, {valid4, gnt4, idx4},
                 {1'b1, eg, 2'(exp_idx[k])});
      end
      cyc();
    end
    // ptr is now 1; an idle cycle with ready high must leave it there
    req4 = 4'b0000;
    #1;
    total++;
    if ({valid4, gnt4, idx4} !== 7'b0) begin
      bad++;
      $display("FAIL rr_zero got=%b want=%b", {valid4, gnt4, idx4}, 7'b0);
    end
    cyc();
    req4 = 4'b1001;
    #1;
    total++;
    if ({valid4, gnt4, idx4} !== {1'b1, 4'b1000, 2'd3}) begin
      bad++;
      $display("FAIL rr_after_zero got=%b want=%b", {valid4, gnt4, idx4}, {1'b1, 4'b1000, 2'd3});
    end
    cyc();
  endtask

  task automatic test_lock();
    logic [3:0] reqs[5]  = '{4'b0101, 4'b0111, 4'b0111, 4'b0101, 4'b0101};
    logic       rdys[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [6:0] wants[5] = '{{1'b1, 4'b0001, 2'd0}, {1'b1, 4'b0001, 2'd0},
                             {1'b1, 4'b0001, 2'd0}, {1'b1, 4'b0001, 2'd0},
                             {1'b1, 4'b0100, 2'd2}};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req4   = reqs[k];
      ready4 = rdys[k];
      #1;
      total++;
      if ({valid4, gnt4, idx4} !== wants[k]) begin
        bad++;
        $display("FAIL lock[%0d] got=%b want=%b", k, {valid4, gnt4, idx4}, wants[k]);
      end
      cyc();
    end
  endtask

  task automatic test_drop();
    do_reset();
    req4   = 4'b0001;
    ready4 = 1'b1;
    cyc();
    req4   = 4'b0100;
    ready4 = 1'b0;
    #1;
    total++;
    if ({valid4, gnt4, idx4} !== {1'b1, 4'b0100, 2'd2}) begin
      bad++;
      $display("FAIL drop_grant got=%b want=%b", {valid4, gnt4, idx4}, {1'b1, 4'b0100, 2'd2});
    end
    cyc();
    // Locked on 2; a wiggle on ready must not disturb valid
    req4   = 4'b0100;
    ready4 = 1'b1;
    #1;
    ready4 = 1'b0;
    total++;
    if (valid4 !== 1'b1) begin
      bad++;
      $display("FAIL drop_ready_indep valid=%b want=1", valid4);
    end
    #1;
    req4   = 4'b0011;
    ready4 = 1'b1;
    #1;
    total++;
    if ({valid4, gnt4, idx4} !== 7'b0) begin
      bad++;
      $display("FAIL drop_withdraw got=%b want=%b", {valid4, gnt4, idx4}, 7'b0);
    end
    cyc();
    ready4 = 1'b0;
    #1;
    total++;
    if ({valid4, gnt4, idx4} !== {1'b1, 4'b0010, 2'd1}) begin
      bad++;
      $display("FAIL drop_restart got=%b want=%b", {valid4, gnt4, idx4}, {1'b1, 4'b0010, 2'd1});
    end
    ready4 = 1'b1;
    cyc();
  endtask

  task automatic test_wrap3();
    int exp_idx[5] = '{0, 1, 2, 0, 1};
    do_reset();
    req3   = 3'b111;
    ready3 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if ({valid3, gnt3, idx3} !== {1'b1, 3'(1 << exp_idx[k]), 2'(exp_idx[k])}) begin
        bad++;
        $display("FAIL wrap3[%0d] got=%b want=%b", k, {valid3, gnt3, idx3},
                 {1'b1, 3'(1 << exp_idx[k]), 2'(exp_idx[k])});
      end
      cyc();
    end
  endtask

  task automatic test_fixed();
    logic [3:0] reqs[6]  = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1010};
    logic [6:0] wants[6] = '{{1'b1, 4'b0010, 2'd1}, {1'b1, 4'b0010, 2'd1},
                             {1'b1, 4'b0010, 2'd1}, {1'b1, 4'b0010, 2'd1},
                             {1'b1, 4'b1000, 2'd3}, {1'b1, 4'b0010, 2'd1}};
    do_reset();
    readyf = 1'b1;
    for (int k = 0; k < 6; k++) begin
      reqf = reqs[k];
      #1;
      total++;
      if ({validf, gntf, idxf} !== wants[k]) begin
        bad++;
        $display("FAIL fixed[%0d] got=%b want=%b", k, {validf, gntf, idxf}, wants[k]);
      end
      cyc();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req4   = 4'b0101;
    ready4 = 1'b0;
    cyc();
    #1;
    total++;
    if ({valid4, gnt4} !== {1'b1, 4'b0001}) begin
      bad++;
      $display("FAIL areset_locked got=%b want=%b", {valid4, gnt4}, {1'b1, 4'b0001});
    end
    rst_i = 1'b1;
    #1;
    total++;
    if ({valid4, gnt4, idx4} !== 7'b0) begin
      bad++;
      $display("FAIL areset_drop got=%b want=%b", {valid4, gnt4, idx4}, 7'b0);
    end
    rst_i = 1'b0;
    req4  = 4'b1000;
    #1;
    total++;
    if ({valid4, gnt4, idx4} !== {1'b1, 4'b1000, 2'd3}) begin
      bad++;
      $display("FAIL areset_after got=%b want=%b", {valid4, gnt4, idx4}, {1'b1, 4'b1000, 2'd3});
    end
    ready4 = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    do_reset();
    req1   = 1'b1;
    ready1 = 1'b0;
    #1;
    total++;
    if ({valid1, gnt1, idx1} !== 3'b110) begin
      bad++;
      $display("FAIL one_grant got=%b want=%b", {valid1, gnt1, idx1}, 3'b110);
    end
    cyc();
    req1 = 1'b0;
    #1;
    total++;
    if ({valid1, gnt1, idx1} !== 3'b000) begin
      bad++;
      $display("FAIL one_withdraw got=%b want=%b", {valid1, gnt1, idx1}, 3'b000);
    end
    cyc();
    req1   = 1'b1;
    ready1 = 1'b1;
    #1;
    total++;
    if ({valid1, gnt1, idx1} !== 3'b110) begin
      bad++;
      $display("FAIL one_regrant got=%b want=%b", {valid1, gnt1, idx1}, 3'b110);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_rr_cycle();
    test_lock();
    test_drop();
    test_wrap3();
    test_fixed();
    test_async_reset();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpdcache_prio_rr_arbiter.md
HPDCACHE_PRIO_RR_ARBITER -- requirements
Module: hpdcache_prio_rr_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters; legal range 1..64.
REQ-002 Parameter RR, default 1, mode; 1 = round-robin, 0 = fixed priority with index 0 highest.
REQ-003 Derived width W = 1 if N == 1, else ceil(log2(N)).
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset; asynchronous, active-high.
REQ-006 req_i  input  N  request vector, one bit per requester.
REQ-007 gnt_o  output  N  one-hot grant vector, all-zero when valid_o is 0.
REQ-008 gnt_idx_o  output  W  binary index of the set gnt_o bit; 0 when valid_o is 0.
REQ-009 valid_o  output  1  a grant is presented downstream.
REQ-010 ready_i  input  1  downstream accepts; a handshake is valid_o & ready_i in the same cycle.

Function
REQ-011 The block SHALL have two states: IDLE (free arbitration) and LOCKED (grant frozen, awaiting ready_i).
REQ-012 In IDLE, valid_o SHALL equal |req_i combinationally, with zero-cycle latency.
REQ-013 In IDLE with RR=1, gnt_o SHALL select the first set req_i bit at or above pointer ptr, scanning upward and wrapping from N-1 to 0.
REQ-014 In IDLE with RR=0, gnt_o SHALL select the lowest-index set req_i bit, and ptr SHALL be ignored and held at 0.
REQ-015 gnt_o SHALL have at most one bit set in every cycle, in both states.
REQ-016 In IDLE, if valid_o is 1 and ready_i is 1, the state SHALL remain IDLE.
REQ-017 Under REQ-016, if RR=1, ptr SHALL load (gnt_idx_o + 1) mod N on the next edge.
REQ-018 In IDLE, if valid_o is 1 and ready_i is 0, the state SHALL move to LOCKED and lock_q SHALL capture gnt_o.
REQ-019 In LOCKED, gnt_o SHALL equal lock_q & req_i, and gnt_idx_o SHALL be the index of lock_q.
REQ-020 In LOCKED, valid_o SHALL equal |(lock_q & req_i).
REQ-021 In LOCKED, changes on the other req_i bits SHALL have no effect on gnt_o.
REQ-022 In LOCKED, a handshake SHALL return the state to IDLE, clear lock_q, and advance ptr as in REQ-017.
REQ-023 In LOCKED, if the locked requester deasserts its request, valid_o SHALL be 0 that cycle.
REQ-024 Under REQ-023, the next state SHALL be IDLE, ptr SHALL be unchanged, and lock_q SHALL be cleared.
REQ-025 In LOCKED with the locked request still asserted and ready_i = 0, the state, lock_q and ptr SHALL hold.
REQ-026 ready_i asserted while valid_o is 0 SHALL cause no state, ptr or lock_q change.
REQ-027 All-zero req_i SHALL give valid_o = 0, gnt_o = 0 and gnt_idx_o = 0.
REQ-028 The ptr wrap SHALL be computed modulo N for non-power-of-2 N; ptr SHALL never hold a value >= N.
REQ-029 For N = 1: gnt_o = req_i in IDLE, ptr is constant 0, and the lock behaviour of REQ-018..REQ-025 still applies.
REQ-030 valid_o SHALL never depend combinationally on ready_i.

Reset
REQ-031 While rst_i is 1: state = IDLE, ptr = 0, lock_q = 0, and valid_o, gnt_o and gnt_idx_o are forced to 0 regardless of req_i.
REQ-032 Reset asserted mid-LOCKED SHALL drop the grant immediately, asynchronously, without waiting for a clock edge.
REQ-033 After reset release, the first arbitration SHALL start from ptr = 0.

Verification
REQ-034 N=4, RR=1, req_i=4'b1111, ready_i=1 for 5 cycles -> gnt_idx_o sequence 0,1,2,3,0.
REQ-035 N=4, RR=1, req_i=4'b0101, ready_i=0 for 3 cycles, then 1 -> gnt_o=4'b0001 throughout; after the handshake gnt_o=4'b0100; req_i changing to 4'b0111 while LOCKED does not alter gnt_o.
REQ-036 N=4, LOCKED on index 2, then req_i[2] drops -> valid_o=0 that cycle; the next cycle is IDLE with ptr unchanged, and arbitration restarts from ptr.
REQ-037 N=3, RR=1, req_i=3'b111, ready_i=1 -> gnt_idx_o sequence 0,1,2,0 (wrap at non-power-of-2 N; ptr never reaches 3).
REQ-038 N=4, RR=0, req_i=4'b1010, ready_i=1 for 4 cycles -> gnt_idx_o = 1 every cycle.
REQ-039 rst_i pulsed asynchronously while LOCKED with valid_o=1 -> valid_o and gnt_o go to 0 before the next clock edge; after release with req_i=4'b1000, gnt_idx_o = 3.
REQ-040 Every test SHALL run an assertion that gnt_o is one-hot or zero, that gnt_o is a subset of req_i, and that gnt_o is stable while valid_o & ~ready_i holds with the locked request still asserted.
